// File: rtl/div_pkg.sv
// Shared constants, state encoding and helpers for the radix-2 divider.
package div_pkg;

  localparam int REG_BUS        = 32;
  localparam int DOUBLE_REG_BUS = 64;

  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // Number of shift-subtract iterations for a full 32-bit quotient.
  localparam logic [5:0] DIV_STEPS = 6'd32;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

  // Two's-complement negate when cond is set; used for abs() and sign fixup.
  function automatic logic [REG_BUS-1:0] neg_if(input logic cond,
                                                input logic [REG_BUS-1:0] v);
    return cond ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div.sv
// Multi-cycle radix-2 shift-subtract divider for DIV/DIVU.
// Handshake: EX raises start_i with operands and keeps it high while waiting;
// ready_o high means result_o = {remainder, quotient} is valid and it stays
// valid until start_i drops. annul_i abandons an in-flight division.
module div
  import div_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      signed_div_i,
  input  logic [REG_BUS-1:0]        opdata1_i,
  input  logic [REG_BUS-1:0]        opdata2_i,
  input  logic                      start_i,
  input  logic                      annul_i,
  output logic [DOUBLE_REG_BUS-1:0] result_o,
  output logic                      ready_o
);

  div_state_t                state;
  logic [5:0]                cnt;
  logic [DOUBLE_REG_BUS-1:0] work;
  logic [REG_BUS-1:0]        divisor;
  logic                      dvd_neg;
  logic                      dvs_neg;
  logic                      signed_op;
  logic [REG_BUS:0]          diff;

  // Trial subtraction of the divisor from the top 33 bits of the working reg;
  // the extra bit lets a divisor up to 0xFFFFFFFF be compared correctly.
  always_comb begin
    diff = work[DOUBLE_REG_BUS-1:REG_BUS-1] - {1'b0, divisor};
  end

  // Divider FSM: operand capture, 32 iterations, sign fixup, result hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DIV_FREE;
      cnt       <= 6'd0;
      work      <= '0;
      divisor   <= '0;
      dvd_neg   <= 1'b0;
      dvs_neg   <= 1'b0;
      signed_op <= 1'b0;
      result_o  <= '0;
      ready_o   <= DIV_RESULT_NOT_READY;
    end else begin
      case (state)
        DIV_FREE: begin
          result_o <= '0;
          ready_o  <= DIV_RESULT_NOT_READY;
          // annul_i wins over start_i so a flushed instruction never starts.
          if (start_i == DIV_START && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DIV_BY_ZERO;
            end else begin
              divisor   <= neg_if(signed_div_i && opdata2_i[REG_BUS-1], opdata2_i);
              work      <= {{REG_BUS{1'b0}},
                            neg_if(signed_div_i && opdata1_i[REG_BUS-1], opdata1_i)};
              cnt       <= 6'd0;
              dvd_neg   <= opdata1_i[REG_BUS-1];
              dvs_neg   <= opdata2_i[REG_BUS-1];
              signed_op <= signed_div_i;
              state     <= DIV_ON;
            end
          end
        end

        DIV_BY_ZERO: begin
          result_o <= '0;
          if (annul_i) begin
            ready_o <= DIV_RESULT_NOT_READY;
            state   <= DIV_FREE;
          end else begin
            ready_o <= DIV_RESULT_READY;
            state   <= DIV_END;
          end
        end

        DIV_ON: begin
          if (annul_i) begin
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
            state    <= DIV_FREE;
          end else if (cnt != DIV_STEPS) begin
            if (diff[REG_BUS]) begin
              work <= {work[DOUBLE_REG_BUS-2:0], 1'b0};
            end else begin
              work <= {diff[REG_BUS-1:0], work[REG_BUS-2:0], 1'b1};
            end
            cnt <= cnt + 6'd1;
          end else begin
            // Quotient takes the XOR of the signs, remainder follows the dividend.
            result_o <= {neg_if(signed_op && dvd_neg, work[DOUBLE_REG_BUS-1:REG_BUS]),
                         neg_if(signed_op && (dvd_neg ^ dvs_neg), work[REG_BUS-1:0])};
            ready_o  <= DIV_RESULT_READY;
            state    <= DIV_END;
          end
        end

        DIV_END: begin
          if (start_i == DIV_STOP) begin
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
            state    <= DIV_FREE;
          end
        end

        default: begin
          state    <= DIV_FREE;
          result_o <= '0;
          ready_o  <= DIV_RESULT_NOT_READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the radix-2 divider: scoreboard of expected
// {remainder, quotient} values produced by an independent arithmetic model.
module tb_div;
  import div_pkg::*;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model: MIPS DIV/DIVU semantics, computed in 64-bit to avoid overflow.
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  task automatic pop_and_check(input string tag);
    logic [63:0] exp;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      exp = exp_q.pop_front();
      check(tag, result_o, exp);
    end
  endtask

  // Wait (on negedges) until ready_o; returns edges elapsed after the sampling edge.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- driver ----------------
  // Full transaction: issue, scramble inputs while busy, wait, check latency,
  // result and hold in DivEnd, then drop start and check the return to idle.
  task automatic do_div(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b);
    int n;
    int exp_lat;
    exp_lat = (b == 32'd0) ? 1 : 33;
    exp_q.push_back(model(s, a, b));
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(negedge clk);                  // sampling edge E0 has passed
    signed_div_i = ~s;
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    wait_ready(n);
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    pop_and_check(tag);
    repeat (2) @(negedge clk);
    check({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
    start_i = 1'b0;
    @(negedge clk);
    check({tag, "_drop_rdy"}, 64'(ready_o), 64'd0);
    check({tag, "_drop_res"}, result_o, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rdy", 64'(ready_o), 64'd0);
    check("rst_res", result_o, 64'd0);
    check("rst_state", 64'(dut.state), 64'(DIV_FREE));
    rst = 1'b0;

    // Directed cases
    do_div("divu_7_2", 1'b0, 32'd7, 32'd2);
    check("const_7_2", model(1'b0, 32'd7, 32'd2), 64'h00000001_00000003);
    do_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2);
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE);
    do_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1);
    do_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF);
    do_div("divu_big_dvs", 1'b0, 32'h12345678, 32'hFFFFFFFF);
    do_div("divu_max_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE);
    do_div("div_m_m", 1'b1, 32'h80000001, 32'h80000000);

    // Divide by zero, with the FSM walk observed
    exp_q.push_back(64'd0);
    @(negedge clk);
    signed_div_i = 1'b1;
    opdata1_i    = 32'd55;
    opdata2_i    = 32'd0;
    start_i      = 1'b1;
    @(negedge clk);
    check("byz_st1", 64'(dut.state), 64'(DIV_BY_ZERO));
    check("byz_rdy1", 64'(ready_o), 64'd0);
    @(negedge clk);
    check("byz_st2", 64'(dut.state), 64'(DIV_END));
    check("byz_rdy2", 64'(ready_o), 64'd1);
    pop_and_check("byz_res");
    start_i = 1'b0;
    @(negedge clk);
    check("byz_st3", 64'(dut.state), 64'(DIV_FREE));

    // annul has priority over start in DivFree
    annul_i   = 1'b1;
    start_i   = 1'b1;
    opdata1_i = 32'd10;
    opdata2_i = 32'd3;
    repeat (2) @(negedge clk);
    check("annul_idle_st", 64'(dut.state), 64'(DIV_FREE));
    annul_i = 1'b0;
    start_i = 1'b0;

    // annul mid-iteration
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    @(negedge clk);
    repeat (10) @(negedge clk);
    check("annul_pre_st", 64'(dut.state), 64'(DIV_ON));
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul_st", 64'(dut.state), 64'(DIV_FREE));
    check("annul_rdy", 64'(ready_o), 64'd0);
    check("annul_res", result_o, 64'd0);
    do_div("divu_100_7", 1'b0, 32'd100, 32'd7);
    check("const_100_7", model(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);

    // Asynchronous reset mid-iteration
    @(negedge clk);
    opdata1_i = 32'hDEADBEEF;
    opdata2_i = 32'd17;
    start_i   = 1'b1;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_mid_st", 64'(dut.state), 64'(DIV_FREE));
    check("arst_mid_rdy", 64'(ready_o), 64'd0);
    check("arst_mid_res", result_o, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst     = 1'b0;

    // Asynchronous reset while holding a result in DivEnd
    exp_q.push_back(model(1'b0, 32'd81, 32'd4));
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd81;
    opdata2_i    = 32'd4;
    start_i      = 1'b1;
    @(negedge clk);
    wait_ready(n);
    pop_and_check("arst_end_pre");
    #2 rst = 1'b1;
    #1;
    check("arst_end_rdy", 64'(ready_o), 64'd0);
    check("arst_end_res", result_o, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst     = 1'b0;
    do_div("divu_9_3", 1'b0, 32'd9, 32'd3);

    // Random mix, including small divisors and large magnitudes
    for (int i = 0; i < 12; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i == 5) b = 32'd0;
      do_div("rand", 1'(i % 2), a, b);
    end

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so the bench always ends on its own.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle radix-2 shift-subtract divider for DIV/DIVU.
- Instantiated beside the EX stage: EX issues operands, holds the pipeline via its stall request while ready_o is low, then forwards result_o to ex_mem as the HI/LO write (HI=remainder, LO=quotient).
- One division in flight; busy/idle is governed by a 4-state FSM.

Parameters:
- None. The datapath is fixed at 32-bit operands and a 64-bit result via the shared defines (RegBus, DoubleRegBus).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- signed_div_i  in  1  1 = signed DIV, 0 = DIVU
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  request division (DivStart/DivStop)
- annul_i  in  1  cancel current operation (branch-delay or exception flush)
- result_o  out  64  {remainder[31:0], quotient[31:0]}
- ready_o  out  1  result valid (DivResultReady/DivResultNotReady)

Behaviour:
- Reset: clk and reset are named as in the codebase (clk, rst); reset is asynchronous and active-high. rst high at any time, including mid-division, forces state=DivFree, cnt=0, working reg=0, result_o=0, ready_o=0.
- States: DivFree, DivByZero, DivOn, DivEnd (2-bit encodings, 00/01/10/11).
- DivFree, start_i=1, annul_i=0 (edge E0):
  - opdata2_i==0 -> DivByZero.
  - otherwise latch |opdata1_i| and |opdata2_i|. Two's-complement negate only if signed_div_i=1 and the operand MSB=1.
  - set W={32'b0, |dividend|}, cnt=0 -> DivOn.
  - Also latch the operand signs and signed_div_i.
- DivFree otherwise: hold; ready_o=0, result_o=0.
- DivByZero: next edge -> DivEnd with result_o=0, ready_o=1.
- DivOn, cnt<32, one step per edge:
  - D = W[63:31] - {1'b0, divisor} (33-bit).
  - D[32]=1: W = W<<1.
  - else: W = {D[31:0], W[30:0], 1'b1}.
  - cnt++.
- DivOn, cnt==32, fixup edge:
  - Q=W[31:0], R=W[63:32].
  - If signed and dividend sign != divisor sign, Q=-Q.
  - If signed and dividend negative, R=-R.
  - result_o={R,Q}, ready_o=1 -> DivEnd.
- Latency: start sampled at E0; iterations at E1..E32; ready_o and result_o valid after E33. Divide-by-zero: valid after E1.
- DivEnd:
  - Hold result_o and ready_o while start_i=1.
  - start_i=0 -> DivFree with result_o=0, ready_o=0.
- annul_i=1 in DivByZero/DivOn -> DivFree next edge, ready_o=0, result_o=0; no result is produced.
- annul_i in DivFree has priority over start_i: stay idle.
- start_i changes or new operands while busy are ignored; latched values are used.
- Signed 0x80000000 / 0xFFFFFFFF gives Q=0x80000000, R=0 (wraps, no trap).
- Unsigned divisor magnitude up to 0xFFFFFFFF is handled by the 33-bit compare.

Decomposition:
- defines.v holds:
  - DivFree/DivByZero/DivOn/DivEnd
  - DivStart/DivStop
  - DivResultReady/DivResultNotReady
  - RegBus/DoubleRegBus widths
- Single module with no sub-module. The abs/negate helpers are inline expressions.
- Stall-request generation stays in the EX stage (stallreq = start && !ready).

Test Plan:
- DIVU 7/2 (start held) -> ready_o rises exactly 33 cycles after the sampling edge, result_o=64'h00000001_00000003; drop start -> ready_o=0, result_o=0 next edge.
- DIV 0xFFFFFFF9 / 2 -> result_o=64'hFFFFFFFF_FFFFFFFD; DIV 7 / 0xFFFFFFFE -> 64'h00000001_FFFFFFFD.
- DIVU 0xFFFFFFFF / 1 -> 64'h00000000_FFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> 64'h00000000_80000000.
- Divisor 0 with start -> ready_o=1 after second edge, result_o=0; FSM walks DivFree->DivByZero->DivEnd.
- annul_i pulsed at iteration 10 -> DivFree next edge, ready_o never asserts; an immediately following DIVU 100/7 returns 64'h00000002_0000000E.
- rst asserted asynchronously mid-iteration (between edges) -> ready_o/result_o are 0 immediately; after release, a new DIVU 9/3 gives 64'h00000000_00000003.
